cmip_fifo_rd_dnsz: RTL and testbench
====================================

// Module: cmip_fifo_rd_dnsz
// PURPOSE
//  Read-side consumer for the FWFT async FIFO (512b words, rd_clk domain). Pops one wide word per
//  request, holds it, and emits it as RATIO narrow beats on a valid/ready stream to the downstream
//  packetiser. Sustains 1 beat/clk with no bubble between words. Never pops an empty FIFO.
// PARAMETERS
//  IN_WDTH    512                 FIFO word width (o_dout width of the FIFO)
//  OUT_WDTH   128                 output beat width; IN_WDTH % OUT_WDTH == 0, RATIO >= 2
//  RATIO      IN_WDTH/OUT_WDTH    beats per word (derived, do not override)
//  BEAT_WDTH  $clog2(RATIO)       beat index width (derived)
//  LSB_FIRST  1                   1: beat0 = word[OUT_WDTH-1:0]; 0: beat0 = MS slice
//  CNT_WDTH   32                  word counter width
// PORTS
//  i_clk          in   1          read clock (same as FIFO i_rd_clk)
//  i_rst_n        in   1          asynchronous active-low reset
//  i_fifo_empty   in   1          FIFO o_empty
//  i_fifo_dout    in   IN_WDTH    FIFO o_dout (FWFT: valid whenever !i_fifo_empty)
//  o_fifo_rd      out  1          FIFO i_rd, combinational pop strobe
//  i_flush        in   1          sync flush: discard held word, return to IDLE
//  o_dat          out  OUT_WDTH   beat data
//  o_vld          out  1          beat valid
//  i_rdy          in   1          downstream ready
//  o_sop          out  1          beat is first slice of a word (qualified by o_vld)
//  o_eop          out  1          beat is last slice of a word (qualified by o_vld)
//  o_busy         out  1          word held (state != IDLE)
//  o_word_cnt     out  CNT_WDTH   words fully emitted (last beat accepted), wraps at 2^CNT_WDTH
// BEHAVIOUR
//  - Reset: state=IDLE, hold_vld=0, beat_idx=0, hold_word=0, o_word_cnt=0; o_vld/o_sop/o_eop=0,
//    o_fifo_rd=0, o_busy=0, o_dat=0.
//  - States: IDLE (no word held), STREAM (word held, beats pending).
//  - last_acc = STREAM & (beat_idx==RATIO-1) & i_rdy.
//  - o_fifo_rd = !i_fifo_empty & !i_flush & (IDLE | last_acc). Never high while i_fifo_empty.
//  - Pop cycle: hold_word <= i_fifo_dout, beat_idx <= 0, state <= STREAM.
//  - IDLE->STREAM on pop. STREAM: i_rdy & beat_idx<RATIO-1 -> beat_idx+1;
//    last_acc & pop -> reload, stay STREAM (no bubble); last_acc & !pop -> IDLE, beat_idx <= 0.
//  - Latency: empty falls in cycle N while IDLE -> o_fifo_rd in N -> o_vld first beat in N+1.
//  - o_vld = (state==STREAM). o_dat = slice beat_idx of hold_word (slice RATIO-1-beat_idx if
//    LSB_FIRST=0), muxed from registers only. o_sop = beat_idx==0; o_eop = beat_idx==RATIO-1.
//  - Handshake: with o_vld & !i_rdy, o_dat/o_sop/o_eop/beat_idx hold stable; o_vld never drops
//    without acceptance except on i_flush or reset.
//  - o_word_cnt +1 on each last_acc; wraps to 0.
//  - i_flush (any state, priority over everything): next cycle state=IDLE, beat_idx=0, held word
//    discarded (not counted even if last_acc same cycle); no pop that cycle; FIFO contents
//    untouched. Pops resume the cycle after flush deasserts.
//  - Reset asserted mid-word: held word lost, outputs to reset values asynchronously.
//  - i_fifo_empty rising while STREAM: no effect until last_acc; then IDLE.
// STRUCTURE
//  - Shared package cmip_pkg: state enum (ST_IDLE, ST_STREAM), RATIO/BEAT_WDTH derivation function.
//  - One natural sub-module: cmip_beat_mux (IN_WDTH, OUT_WDTH, LSB_FIRST) -- comb slice select.
//  - Intended pairing: cmip_async_fifo with FWFT=1 on read side.
// TESTING  (IN_WDTH=512, OUT_WDTH=128, LSB_FIRST=1)
//  1 Reset; FIFO empty, i_rdy=1 for 20 clk -> o_fifo_rd never 1, o_vld=0, o_word_cnt=0.
//  2 Preload words W0..W3, i_rdy=1 -> 16 contiguous beats, W0[127:0] first, o_fifo_rd pulses at
//    beats 0/4/8/12 edges only, sop/eop on beats 0,4,.../3,7,..., o_word_cnt=4, then IDLE.
//  3 One word, i_rdy low 5 clk at beat 2 -> o_dat/o_eop held stable, beat 2 emitted once, total 4.
//  4 i_flush at beat 1 of W0 with W1 queued -> W0 beats 2,3 never appear, no pop in flush cycle,
//    next o_vld carries W1 beat 0 with o_sop=1, o_word_cnt counts W1 only.
//  5 LSB_FIRST=0, word 0x..._0003_..._0002_..._0001_..._0000 slices -> beats 3,2,1,0.
//  6 Assert i_rst_n low at beat 2 -> outputs zero immediately; after release re-reads next word.

Source files
------------

// File: rtl/cmip_pkg.sv
// Shared definitions for the CMIP FIFO read-side width converter.
//   state_t        : controller states (ST_IDLE: no word held, ST_STREAM: beats pending)
//   calc_ratio     : narrow beats per wide word
//   calc_beat_wdth : width of a beat index able to address every beat
package cmip_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic int calc_ratio(input int in_wdth, input int out_wdth);
    return in_wdth / out_wdth;
  endfunction

  // A one-bit index is kept even for degenerate ratios so port widths stay legal.
  function automatic int calc_beat_wdth(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/cmip_beat_mux.sv
// Combinational slice selector: picks narrow beat beat_idx out of a wide word.
//   word     in  IN_WDTH    held wide word
//   beat_idx in  BEAT_WDTH  beat number (0 = first beat on the wire)
//   dat      out OUT_WDTH   selected slice
// LSB_FIRST=1 sends the least significant slice first; 0 sends the most
// significant slice first.
module cmip_beat_mux #(
  parameter int IN_WDTH   = 512,
  parameter int OUT_WDTH  = 128,
  parameter int LSB_FIRST = 1,
  parameter int BEAT_WDTH = 2
) (
  input  logic [IN_WDTH-1:0]   word,
  input  logic [BEAT_WDTH-1:0] beat_idx,
  output logic [OUT_WDTH-1:0]  dat
);

  localparam int RATIO = IN_WDTH / OUT_WDTH;

  logic [OUT_WDTH-1:0] slices [RATIO];

  // Reorder slices at elaboration time so the runtime select is a plain index.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    if (LSB_FIRST != 0) begin : g_lsb
      assign slices[gi] = word[gi*OUT_WDTH +: OUT_WDTH];
    end else begin : g_msb
      assign slices[gi] = word[(RATIO-1-gi)*OUT_WDTH +: OUT_WDTH];
    end
  end

  assign dat = slices[beat_idx];

endmodule

// File: rtl/cmip_fifo_rd_dnsz.sv
// Read-side consumer for an FWFT FIFO: pops one wide word, holds it and
// emits it as RATIO narrow beats on a valid/ready stream, back to back across
// words when the FIFO has data.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_fifo_empty   : FIFO empty flag;  i_fifo_dout: FIFO head word (FWFT)
//   o_fifo_rd      : combinational pop strobe to the FIFO
//   i_flush        : discard held word and return to idle
//   o_dat/o_vld/i_rdy/o_sop/o_eop : narrow output stream
//   o_busy         : a word is held
//   o_word_cnt     : words whose last beat was accepted (wrapping)
module cmip_fifo_rd_dnsz
  import cmip_pkg::*;
#(
  parameter int IN_WDTH   = 512,
  parameter int OUT_WDTH  = 128,
  parameter int LSB_FIRST = 1,
  parameter int CNT_WDTH  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_fifo_empty,
  input  logic [IN_WDTH-1:0]  i_fifo_dout,
  output logic                o_fifo_rd,
  input  logic                i_flush,
  output logic [OUT_WDTH-1:0] o_dat,
  output logic                o_vld,
  input  logic                i_rdy,
  output logic                o_sop,
  output logic                o_eop,
  output logic                o_busy,
  output logic [CNT_WDTH-1:0] o_word_cnt
);

  localparam int RATIO     = calc_ratio(IN_WDTH, OUT_WDTH);
  localparam int BEAT_WDTH = calc_beat_wdth(RATIO);
  localparam logic [BEAT_WDTH-1:0] LAST_BEAT = BEAT_WDTH'(RATIO - 1);

  state_t               state_reg, state_next;
  logic [BEAT_WDTH-1:0] beat_idx_reg, beat_idx_next;
  logic [IN_WDTH-1:0]   hold_word_reg, hold_word_next;
  logic [CNT_WDTH-1:0]  word_cnt_reg, word_cnt_next;

  logic streaming;
  logic last_acc;
  logic pop;

  assign streaming = (state_reg == ST_STREAM);
  assign last_acc  = streaming && (beat_idx_reg == LAST_BEAT) && i_rdy;
  // Pop when nothing is held or the held word is leaving this cycle, which
  // lets the next word load with no idle beat. Reset is folded in because the
  // idle state alone would otherwise request a pop while reset is held.
  assign pop = i_rst_n && !i_fifo_empty && !i_flush && (!streaming || last_acc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      beat_idx_reg  <= '0;
      hold_word_reg <= '0;
      word_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      beat_idx_reg  <= beat_idx_next;
      hold_word_reg <= hold_word_next;
      word_cnt_reg  <= word_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    beat_idx_next  = beat_idx_reg;
    hold_word_next = hold_word_reg;
    word_cnt_next  = word_cnt_reg;
    if (i_flush) begin
      // Flush wins even over a final-beat acceptance: that word is not counted.
      state_next    = ST_IDLE;
      beat_idx_next = '0;
    end else begin
      if (last_acc) begin
        word_cnt_next = word_cnt_reg + CNT_WDTH'(1);
      end
      if (pop) begin
        hold_word_next = i_fifo_dout;
        beat_idx_next  = '0;
        state_next     = ST_STREAM;
      end else if (streaming && i_rdy) begin
        if (beat_idx_reg == LAST_BEAT) begin
          state_next    = ST_IDLE;
          beat_idx_next = '0;
        end else begin
          beat_idx_next = beat_idx_reg + BEAT_WDTH'(1);
        end
      end
    end
  end

  cmip_beat_mux #(
    .IN_WDTH  (IN_WDTH),
    .OUT_WDTH (OUT_WDTH),
    .LSB_FIRST(LSB_FIRST),
    .BEAT_WDTH(BEAT_WDTH)
  ) u_beat_mux (
    .word    (hold_word_reg),
    .beat_idx(beat_idx_reg),
    .dat     (o_dat)
  );

  assign o_fifo_rd  = pop;
  assign o_vld      = streaming;
  assign o_busy     = streaming;
  // Qualified with the state so both flags read zero while idle and in reset.
  assign o_sop      = streaming && (beat_idx_reg == '0);
  assign o_eop      = streaming && (beat_idx_reg == LAST_BEAT);
  assign o_word_cnt = word_cnt_reg;

endmodule

// File: tb/tb_cmip_fifo_rd_dnsz.sv
// Scoreboard bench: words issued to a queue-based FIFO are also handed to a
// beat-level reference model; a monitor compares both DUT flavours
// (LSB-first and MSB-first) against it every cycle.
module tb_cmip_fifo_rd_dnsz;

  localparam int IW = 512;
  localparam int OW = 128;
  localparam int NB = IW / OW;

  typedef struct {
    logic [OW-1:0] dat;
    logic [OW-1:0] dat_rev;
    bit            sop;
    bit            eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [IW-1:0] fifo_dout;
  logic          flush;
  logic          rdy;

  logic          fifo_rd, vld, sop, eop, busy;
  logic [OW-1:0] dat;
  logic [31:0]   word_cnt;
  logic          fifo_rd_b, vld_b, sop_b, eop_b, busy_b;
  logic [OW-1:0] dat_b;
  logic [31:0]   word_cnt_b;

  always #5 clk = ~clk;

  cmip_fifo_rd_dnsz #(.IN_WDTH(IW), .OUT_WDTH(OW), .LSB_FIRST(1), .CNT_WDTH(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(fifo_empty), .i_fifo_dout(fifo_dout),
    .o_fifo_rd(fifo_rd), .i_flush(flush), .o_dat(dat), .o_vld(vld), .i_rdy(rdy),
    .o_sop(sop), .o_eop(eop), .o_busy(busy), .o_word_cnt(word_cnt)
  );

  cmip_fifo_rd_dnsz #(.IN_WDTH(IW), .OUT_WDTH(OW), .LSB_FIRST(0), .CNT_WDTH(32)) u_dut_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(fifo_empty), .i_fifo_dout(fifo_dout),
    .o_fifo_rd(fifo_rd_b), .i_flush(flush), .o_dat(dat_b), .o_vld(vld_b), .i_rdy(rdy),
    .o_sop(sop_b), .o_eop(eop_b), .o_busy(busy_b), .o_word_cnt(word_cnt_b)
  );

  // ---------------- stimulus side (owns the FIFO contents) ----------------
  logic [IW-1:0] fifo_q [$];
  logic [IW-1:0] issued [$];
  int            drain_seq = 0;
  bit            drain_ok  = 1'b0;

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [IW-1:0] w);
    fifo_q.push_back(w);
    issued.push_back(w);
    refresh();
  endtask

  // One clock: the FIFO pops on the edge if the DUT strobed read beforehand.
  task automatic tick();
    logic rd_s;
    @(negedge clk);
    rd_s = fifo_rd;
    @(posedge clk);
    if (rd_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    refresh();
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 20 && !vld; i++) tick();
  endtask

  function automatic logic [IW-1:0] rnd_word();
    logic [IW-1:0] w;
    for (int i = 0; i < IW/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // ---------------- monitor / reference model ----------------
  int    n_pass  = 0;
  int    n_total = 0;
  beat_t exp_q [$];
  int    mdl_rd  = 0;
  logic [31:0] m_cnt = 0;
  int    drain_seen = 0;

  function automatic void chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
  endfunction

  always @(negedge clk) begin
    beat_t         e;
    logic [IW-1:0] w;
    bit            pred_rd;
    if (drain_seq != drain_seen) begin
      drain_seen = drain_seq;
      chk("drain_done", OW'(drain_ok), OW'(1));
    end
    if (!rst_n) begin
      // Held word is lost; the FIFO keeps whatever it still holds.
      exp_q.delete();
      m_cnt = 0;
      chk("rst_ctrl", OW'({vld, sop, eop, fifo_rd, busy}), OW'(0));
      chk("rst_dat", dat, OW'(0));
      chk("rst_cnt", OW'(word_cnt), OW'(0));
    end else begin
      chk("vld", OW'(vld), OW'(exp_q.size() != 0));
      chk("busy", OW'(busy), OW'(exp_q.size() != 0));
      chk("word_cnt", OW'(word_cnt), OW'(m_cnt));
      if (vld && exp_q.size() != 0) begin
        e = exp_q[0];
        chk("dat", dat, e.dat);
        chk("dat_msb_first", dat_b, e.dat_rev);
        chk("sop_eop", OW'({sop, eop}), OW'({e.sop, e.eop}));
      end
      // Advance the model across the coming clock edge.
      pred_rd = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && rdy) begin
          e = exp_q.pop_front();
          if (e.eop) m_cnt = m_cnt + 1;
        end
        if (exp_q.size() == 0 && issued.size() > mdl_rd) begin
          pred_rd = 1'b1;
          w = issued[mdl_rd];
          mdl_rd++;
          for (int k = 0; k < NB; k++) begin
            e.dat     = w[k*OW +: OW];
            e.dat_rev = w[(NB-1-k)*OW +: OW];
            e.sop     = (k == 0);
            e.eop     = (k == NB-1);
            exp_q.push_back(e);
          end
        end
      end
      chk("fifo_rd", OW'(fifo_rd), OW'(pred_rd));
    end
  end

  // ---------------- directed and random sequences ----------------
  initial begin
    logic [IW-1:0] pat;
    rst_n = 1'b0;
    flush = 1'b0;
    rdy   = 1'b1;
    refresh();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty FIFO: nothing may be read or emitted.
    repeat (20) tick();

    // Four back-to-back words; the first has slice k equal to k.
    for (int k = 0; k < NB; k++) pat[k*OW +: OW] = OW'(k);
    push_word(pat);
    for (int i = 0; i < 3; i++) push_word(rnd_word());
    repeat (24) tick();

    // Backpressure for 5 cycles on beat 2.
    push_word(rnd_word());
    wait_vld();
    tick();
    tick();
    rdy = 1'b0;
    repeat (5) tick();
    rdy = 1'b1;
    repeat (6) tick();

    // Flush on beat 1 with a second word queued.
    push_word(rnd_word());
    push_word(rnd_word());
    wait_vld();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();

    // Reset in the middle of a word, next word read after release.
    push_word(rnd_word());
    push_word(rnd_word());
    wait_vld();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();

    // Random traffic with backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(0, 31) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) push_word(rnd_word());
      tick();
    end

    flush = 1'b0;
    rdy   = 1'b1;
    drain_ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() == 0 && !vld) begin
        drain_ok = 1'b1;
        break;
      end
      tick();
    end
    drain_seq = drain_seq + 1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
